// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the memory arbiter and the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10,
        ARB_RESP = 2'b11
    } arb_state_t;

endpackage

// File: rtl/ahb_mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: one-hot grant, the master not served last wins a tie.
module rr_pick2
    import ahb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Lone requester wins; on a tie, last=1 (M1 served last) hands the grant to M0.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-master round-robin arbiter and single-outstanding transfer sequencer for
// the AHB memory slave, with a watchdog on the data-phase wait.
module ahb_mem_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        mem_ready,
    input  logic [1:0]  m_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m0_size,
    input  logic [2:0]  m1_size,
    input  logic        m0_write,
    input  logic        m1_write,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_rvalid,
    output logic [31:0] m_rdata,
    output logic        m_err,
    output logic        HSEL,
    output logic [1:0]  HTRANS,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

    arb_state_t    state;
    logic          last;      // index of the master served last
    logic          owner;     // index of the master owning the current transfer
    logic [CW-1:0] wait_cnt;
    logic [1:0]    pick;

    rr_pick2 u_pick (
        .req  (m_req),
        .last (last),
        .gnt  (pick)
    );

    // Transfer sequencer: all bus and master-side outputs are registered here.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ARB_IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            wait_cnt <= '0;
            m_gnt    <= '0;
            m_rvalid <= '0;
            m_rdata  <= '0;
            m_err    <= 1'b0;
            HSEL     <= 1'b0;
            HTRANS   <= HTRANS_IDLE;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= '0;
            HWDATA   <= '0;
        end else begin
            m_gnt    <= '0;
            m_rvalid <= '0;
            case (state)
                ARB_IDLE: begin
                    HSEL   <= 1'b0;
                    HTRANS <= HTRANS_IDLE;
                    // HREADY gate also keeps a late completion after a timeout from overlapping a new issue.
                    if (mem_ready && HREADY && (pick != 2'b00)) begin
                        state  <= ARB_ADDR;
                        HSEL   <= 1'b1;
                        HTRANS <= HTRANS_NONSEQ;
                        m_gnt  <= pick;
                        owner  <= pick[1];
                        last   <= pick[1];
                        if (pick[1]) begin
                            HADDR  <= m1_addr;
                            HSIZE  <= m1_size;
                            HWRITE <= m1_write;
                            HWDATA <= m1_wdata;
                        end else begin
                            HADDR  <= m0_addr;
                            HSIZE  <= m0_size;
                            HWRITE <= m0_write;
                            HWDATA <= m0_wdata;
                        end
                    end
                end
                ARB_ADDR: begin
                    state    <= ARB_DATA;
                    HSEL     <= 1'b0;
                    HTRANS   <= HTRANS_IDLE;
                    wait_cnt <= '0;
                end
                ARB_DATA: begin
                    if (HREADY) begin
                        state    <= ARB_RESP;
                        m_rdata  <= HRDATA;
                        m_err    <= (HRESP == HRESP_ERROR);
                        m_rvalid <= owner ? 2'b10 : 2'b01;
                    end else if (wait_cnt == WAIT_MAX) begin
                        state    <= ARB_RESP;
                        m_rdata  <= '0;
                        m_err    <= 1'b1;
                        m_rvalid <= owner ? 2'b10 : 2'b01;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_mem_arbiter.md
# ahb_mem_arbiter

Two-master arbiter and transfer sequencer in front of the single-port AHB memory slave. It shares the memory between instruction fetch (M0) and load/store (M1) using round-robin arbitration, with one outstanding transfer at a time. It drives the slave's address and control signals, holds them stable through the data phase, and returns registered read data or an error per master. A watchdog aborts any transfer whose wait phase exceeds a bound.

## Interface
- `TIMEOUT`, default 16: maximum number of consecutive data-phase cycles with HREADY low before the transfer is aborted; must be ≥1.
- `HCLK` in 1: single clock.
- `HRESETn` in 1: asynchronous, active-low reset.
- `mem_ready` in 1: memory image loaded (tied to slave `inst_loaded`). No grant is issued while it is 0.
- `m_req` in 2: per-master request level; held by the master until its `m_gnt` is seen.
- `m0_addr`/`m1_addr` in 32, `m0_size`/`m1_size` in 3, `m0_write`/`m1_write` in 1, `m0_wdata`/`m1_wdata` in 32: per-master request fields.
- `m_gnt` out 2: one-hot, one-cycle pulse during the address phase of the granted master.
- `m_rvalid` out 2: one-hot, one-cycle completion pulse.
- `m_rdata` out 32: shared; valid only while an `m_rvalid` bit is set.
- `m_err` out 1: qualifies `m_rvalid`; set on a slave ERROR response or on timeout.
- `HSEL` out 1, `HTRANS` out 2, `HADDR` out 32, `HWRITE` out 1, `HSIZE` out 3, `HWDATA` out 32: slave request signals.
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 2: slave response signals.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE**
  - Drives HSEL=0 and HTRANS=IDLE(00).
  - Goes to ADDR when `mem_ready` and HREADY are both 1 and any `m_req` bit is set.
  - The winner's fields are latched into HADDR/HSIZE/HWRITE/HWDATA at that edge.
- **ADDR** (exactly 1 cycle)
  - Drives HSEL=1, HTRANS=NONSEQ(10), and `m_gnt[owner]`=1.
  - Then goes to DATA.
- **DATA**
  - Drives HSEL=0 and HTRANS=IDLE.
  - HADDR, HSIZE, HWRITE and HWDATA are held unchanged, because the slave formats HRDATA from the live HSIZE.
  - On HREADY=1: captures HRDATA into `m_rdata`, sets `m_err` = (HRESP==01), and goes to RESP.
  - If the wait counter reaches TIMEOUT: sets `m_rdata`=0 and `m_err`=1, and goes to RESP.
- **RESP** (1 cycle)
  - Drives `m_rvalid[owner]`=1.
  - Then goes to IDLE.
  - `m_rdata` and `m_err` hold their values until the next RESP.
- **Arbitration**
  - Only one master requesting: that master wins.
  - Both requesting: the master not served last wins.
  - The last-served pointer updates on the IDLE→ADDR transition and resets to M1, so M0 wins the first tie.
- **Wait counter**
  - Width is $clog2(TIMEOUT+1) bits.
  - Cleared on entry to DATA; increments each DATA cycle with HREADY=0; saturates.
  - After a timeout, IDLE still waits for HREADY=1 before issuing again, so a late slave completion is never reissued.
- `m_req` is ignored outside IDLE. A requester that keeps `m_req` high after `m_gnt` gets a second transfer.
- HRESP is sampled only in DATA with HREADY=1.

## Timing
- **Reset** (asynchronous assert, synchronous deassert edge): state=IDLE.
  - All outputs are 0: HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, `m_gnt`, `m_rvalid`, `m_rdata`, `m_err`.
  - The pointer selects M1 as last served; the wait counter is 0.
- Reset mid-transfer abandons it; no `m_rvalid` is issued.
- **Latency**, with `m_req` first sampled high in IDLE at edge c:
  - ADDR in cycle c+1.
  - DATA from c+2.
  - For a slave with LATENCY=L (HREADY low for max(L,1) cycles), RESP is at c+3+max(L,1). For L=2, that is c+5.
  - The next IDLE sample is RESP+1.
- **Throughput**: one transfer per 4+max(L,1) cycles.
- All outputs are registered; nothing on the master side depends combinationally on slave inputs.

## Structure
- Shared package `ahb_pkg`: `htrans_t` (IDLE/BUSY/NONSEQ/SEQ), HRESP codes OKAY=00 and ERROR=01, and `arb_state_t`. The same `htrans_t` is reused by the memory slave.
- One sub-module, `rr_pick2`: combinational 2-way round-robin chooser taking (req[1:0], last) and producing a one-hot grant. Kept separate so it can be unit-tested on its own.

## Test plan
- **Single read**: M0 reads 0x04 with HSIZE=2, slave L=2 → `m_gnt[0]` at c+1, HTRANS=10 only at c+1, `m_rvalid[0]` at c+5 with `m_rdata`=mem[1], `m_err`=0.
- **Write then read-back**: M1 writes 0xDEADBEEF to 0x08 → `m_rvalid[1]` with `m_err`=0. A following M1 byte read of 0x0A with HSIZE=0 returns 0x000000AD.
- **Contention**: both request continuously from reset → grants alternate M0,M1,M0,M1, with no grant while a transfer is outstanding.
- **Gating**: `mem_ready`=0 with `m_req`=11 → no `m_gnt` for 20 cycles. Raising `mem_ready` → `m_gnt[0]` 2 cycles later.
- **Faults**: a stub slave holds HREADY low 17 cycles with TIMEOUT=16 → `m_rvalid` with `m_err`=1 and `m_rdata`=0, and no new ADDR until HREADY=1. A stub slave returning HRESP=01 → `m_err`=1.
- **Reset mid-transfer**: HRESETn pulsed low during DATA → all outputs 0 immediately, and no `m_rvalid` for that transfer.
